serial_subtractor: RTL and testbench

Bit-serial N-bit subtractor computing `diff = a - b - borrow_in` LSB-first, one bit per clock, through a single full-subtractor cell. It is the parametrised, sequential successor to the 1-bit combinational full subtractor used in the drills. It trades WIDTH cycles of latency for a one-cell datapath and adds a start/busy/done handshake. It sits between the drill testbenches and any block needing multi-bit subtraction with low area.

---
 rtl/serial_subtractor_pkg.sv | 14 +
 rtl/full_subtract_cell.sv | 18 +
 rtl/serial_subtractor.sv | 119 +++++++++++
 tb/tb_serial_subtractor.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared definitions for the bit-serial subtractor.
//   state_t           - FSM state encoding (S_IDLE=0, S_RUN=1, S_DONE=2)
//   SUB_WIDTH_DEFAULT - default operand width
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int SUB_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/full_subtract_cell.sv
// full_subtract_cell: 1-bit combinational full subtractor, d = x - y - bi.
//   d  - difference bit
//   bo - borrow out
//   x  - minuend bit
//   y  - subtrahend bit
//   bi - borrow in
module full_subtract_cell (
  output logic d,
  output logic bo,
  input  logic x,
  input  logic y,
  input  logic bi
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial diff = a - b - borrow_in, LSB first, one bit
// per clock through a single full_subtract_cell. Latency WIDTH cycles from
// accept to done; one operation per WIDTH+2 cycles.
//   clk, rst          - clock, async active-high reset
//   start             - request, sampled only in IDLE
//   a, b, borrow_in   - operands, captured on accept
//   busy              - high in RUN and DONE
//   done              - one-cycle pulse, result valid from this cycle on
//   diff, borrow_out  - registered result, held until next completion
//   overflow          - signed overflow, only with SERIAL_SUB_OVERFLOW_EN
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr, b_sr, d_sr;
  logic             br;
  logic             d, bo;
  logic             last;

  full_subtract_cell u_cell (
    .d  (d),
    .bo (bo),
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .bi (br)
  );

  assign last = (cnt == LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last)  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic a_msb, b_msb;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      a_sr       <= '0;
      b_sr       <= '0;
      d_sr       <= '0;
      br         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      overflow   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      // status flags follow the next state so they are registered outputs
      busy  <= (state_nxt != S_IDLE);
      done  <= (state_nxt == S_DONE);
      case (state)
        S_IDLE: if (start) begin
          a_sr <= a;
          b_sr <= b;
          br   <= borrow_in;
          cnt  <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
          a_msb <= a[WIDTH-1];
          b_msb <= b[WIDTH-1];
`endif
        end
        S_RUN: begin
          a_sr <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr <= {1'b0, b_sr[WIDTH-1:1]};
          d_sr <= {d, d_sr[WIDTH-1:1]};
          br   <= bo;
          cnt  <= cnt + 1'b1;
          if (last) begin
            // final bit goes straight to the result; d is the result MSB
            diff       <= {d, d_sr[WIDTH-1:1]};
            borrow_out <= bo;
`ifdef SERIAL_SUB_OVERFLOW_EN
            overflow   <= (a_msb != b_msb) & (d != a_msb);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start4;
  logic [7:0] a8, b8;
  logic [3:0] a4, b4;
  logic       bi8, bi4;
  logic       busy8, done8, bo8;
  logic       busy4, done4, bo4;
  logic [7:0] diff8;
  logic [3:0] diff4;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic       ovf8, ovf4;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .borrow_in(bi8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
`ifdef SERIAL_SUB_OVERFLOW_EN
    , .overflow(ovf8)
`endif
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .borrow_in(bi4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4)
`ifdef SERIAL_SUB_OVERFLOW_EN
    , .overflow(ovf4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // issue one op on the 8-bit DUT, then check latency, busy, result
  task automatic run8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input logic biv, input logic [7:0] ed, input logic eb);
    int lat;
    @(negedge clk);
    a8 = av; b8 = bv; bi8 = biv; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    @(negedge clk);
    chk({tag, "_busy"}, 32'(busy8), 32'd1);
    lat = 1;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      if (!done8) lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd8);
    chk({tag, "_diff"}, 32'(diff8), 32'(ed));
    chk({tag, "_bo"}, 32'(bo8), 32'(eb));
    @(negedge clk);
    chk({tag, "_donefall"}, 32'({done8, busy8}), 32'd0);
  endtask

  initial begin
    int ndone;
    rst = 1'b1; start8 = 0; start4 = 0;
    a8 = 0; b8 = 0; bi8 = 0; a4 = 0; b4 = 0; bi4 = 0;
    repeat (2) @(negedge clk);
    chk("rst_out8", {21'd0, busy8, done8, diff8, bo8}, 32'd0);
    chk("rst_out4", {25'd0, busy4, done4, diff4, bo4}, 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("rst_ovf", 32'({ovf8, ovf4}), 32'd0);
`endif
    rst = 1'b0;

    run8("v5m3", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
    run8("v0m1", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("v0m1_ovf", 32'(ovf8), 32'd0);
`endif
    run8("vffmffb", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    run8("v80m1", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("v80m1_ovf", 32'(ovf8), 32'd1);
`endif
    // no borrow, borrow_in used: 0x3C - 0x1A - 1 = 0x21
    run8("v3c1ab", 8'h3C, 8'h1A, 1'b1, 8'h21, 1'b0);

    // start during RUN must be ignored
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h01; bi8 = 0; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 a8 = 8'hAA; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    chk("ign_diff", 32'(diff8), 32'h0F);
    chk("ign_ndone", 32'(ndone), 32'd1);
    chk("ign_idle", 32'(busy8), 32'd0);

    // reset mid-RUN clears outputs immediately
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h11; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("midrst_out", {22'd0, busy8, done8, diff8}, 32'd0);
    chk("midrst_bo", 32'(bo8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run8("v9m4", 8'h09, 8'h04, 1'b0, 8'h05, 1'b0);

    // 4-bit instance: 3 - 5 = 0xE with borrow
    @(negedge clk);
    a4 = 4'h3; b4 = 4'h5; bi4 = 0; start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    begin
      int lat4 = 0;
      @(negedge clk);
      while (!done4 && lat4 < 20) begin
        lat4++;
        @(negedge clk);
      end
      chk("w4_lat", 32'(lat4), 32'd4);
    end
    chk("w4_diff", 32'(diff4), 32'hE);
    chk("w4_bo", 32'(bo4), 32'd1);
`ifdef SERIAL_SUB_OVERFLOW_EN
    // 3 - 5 = -2 fits in 4-bit signed
    chk("w4_ovf", 32'(ovf4), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
